// File: rtl/rsa_probe_pkg.sv
// Shared definitions for the RSA timing probe: controller state encoding and
// default sizing of the latency counter, trial counter and timeout.
package rsa_probe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int WIDTH_DEF    = 8;
   localparam int CNT_W_DEF    = 16;
   localparam int TRIALS_W_DEF = 8;
   localparam int TIMEOUT_DEF  = 65535;

endpackage

// File: rtl/rsa_timing_probe_stats.sv
// Batch latency accumulator: min / max / sum of per-trial latencies and the
// number of trials whose decrypted message did not match.
module rsa_lat_stats #(
   parameter int CNT_W    = 16,
   parameter int TRIALS_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      update,
   input  logic [CNT_W-1:0]          lat,
   input  logic                      mismatch,
   output logic [CNT_W-1:0]          min_o,
   output logic [CNT_W-1:0]          max_o,
   output logic [CNT_W+TRIALS_W-1:0] sum_o,
   output logic [TRIALS_W-1:0]       errors_o
);

   logic [CNT_W-1:0]          min_q, min_d;
   logic [CNT_W-1:0]          max_q, max_d;
   logic [CNT_W+TRIALS_W-1:0] sum_q, sum_d;
   logic [TRIALS_W-1:0]       errors_q, errors_d;

   // Clear to the empty-batch values or fold in one finished trial.
   always_comb begin
      min_d    = min_q;
      max_d    = max_q;
      sum_d    = sum_q;
      errors_d = errors_q;
      if (clear) begin
         min_d    = '1;
         max_d    = '0;
         sum_d    = '0;
         errors_d = '0;
      end else if (update) begin
         min_d    = (lat < min_q) ? lat : min_q;
         max_d    = (lat > max_q) ? lat : max_q;
         sum_d    = sum_q + {{TRIALS_W{1'b0}}, lat};
         errors_d = errors_q + TRIALS_W'(mismatch);
      end
   end

   // Statistic registers; min resets to all-ones so the first trial always wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         min_q    <= '1;
         max_q    <= '0;
         sum_q    <= '0;
         errors_q <= '0;
      end else begin
         min_q    <= min_d;
         max_q    <= max_d;
         sum_q    <= sum_d;
         errors_q <= errors_d;
      end
   end

   assign min_o    = min_q;
   assign max_o    = max_q;
   assign sum_o    = sum_q;
   assign errors_o = errors_q;

endmodule

// File: rtl/rsa_timing_probe.sv
// Drives a batch of RSA trials (start pulse + message base+k), measures the
// cycles until each finish pulse, and returns batch statistics over a
// valid/ready handshake. Aborts the batch if a trial exceeds TIMEOUT cycles.
module rsa_timing_probe
   import rsa_probe_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TRIALS_W = TRIALS_W_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2*WIDTH-1:0]        cmd_m,
   input  logic [TRIALS_W-1:0]       cmd_trials,
   output logic                      rsa_start,
   output logic [2*WIDTH-1:0]        rsa_m,
   input  logic [2*WIDTH-1:0]        rsa_m_decrypted,
   input  logic                      rsa_finish,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [CNT_W-1:0]          res_last,
   output logic [CNT_W-1:0]          res_min,
   output logic [CNT_W-1:0]          res_max,
   output logic [CNT_W+TRIALS_W-1:0] res_sum,
   output logic [TRIALS_W-1:0]       res_errors,
   output logic                      res_timeout
);

   localparam int               MW  = 2 * WIDTH;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_t              state_q, state_d;
   logic [MW-1:0]       base_q, base_d;
   logic [MW-1:0]       m_q, m_d;
   logic [TRIALS_W-1:0] trials_q, trials_d;
   logic [TRIALS_W-1:0] k_q, k_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    last_q, last_d;
   logic                timeout_q, timeout_d;

   logic                stats_clear;
   logic                stats_update;
   logic [CNT_W-1:0]    lat;
   logic                mismatch;
   logic [TRIALS_W:0]   k_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign lat      = sat_inc(cnt_q);
   assign mismatch = (rsa_m_decrypted != m_q);
   assign k_inc    = {1'b0, k_q} + 1'b1;

   // Next-state and datapath control for the batch sequencer.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      m_d          = m_q;
      trials_d     = trials_q;
      k_d          = k_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      timeout_d    = timeout_q;
      stats_clear  = 1'b0;
      stats_update = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               base_d      = cmd_m;
               m_d         = cmd_m;
               trials_d    = (cmd_trials == '0) ? TRIALS_W'(1) : cmd_trials;
               k_d         = '0;
               last_d      = '0;
               timeout_d   = 1'b0;
               stats_clear = 1'b1;
               state_d     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A finish on the timeout cycle still counts as a finish.
            if (rsa_finish) begin
               stats_update = 1'b1;
               last_d       = lat;
               k_d          = k_inc[TRIALS_W-1:0];
               if (k_inc < {1'b0, trials_q}) begin
                  m_d     = base_q + MW'(k_inc);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (cnt_q == TMO) begin
               timeout_d = 1'b1;
               last_d    = cnt_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_GAP: begin
            state_d = ST_LAUNCH;
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and trial registers; reset abandons any batch in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         m_q       <= '0;
         trials_q  <= TRIALS_W'(1);
         k_q       <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         m_q       <= m_d;
         trials_q  <= trials_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end

   rsa_lat_stats #(
      .CNT_W    (CNT_W),
      .TRIALS_W (TRIALS_W)
   ) u_stats (
      .clk      (clk),
      .rst      (rst),
      .clear    (stats_clear),
      .update   (stats_update),
      .lat      (lat),
      .mismatch (mismatch),
      .min_o    (res_min),
      .max_o    (res_max),
      .sum_o    (res_sum),
      .errors_o (res_errors)
   );

   assign cmd_ready   = (state_q == ST_IDLE);
   assign rsa_start   = (state_q == ST_LAUNCH);
   assign rsa_m       = m_q;
   assign res_valid   = (state_q == ST_DONE);
   assign res_last    = last_q;
   assign res_timeout = timeout_q;

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Bench for rsa_timing_probe: a behavioural RSA stub with per-trial latency
// and corruption tables, and a batch-level reference model of the statistics.
module tb_rsa_timing_probe;

   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_m;
   logic [7:0]  cmd_trials;
   logic        rsa_start;
   logic [15:0] rsa_m;
   logic [15:0] rsa_m_decrypted;
   logic        rsa_finish;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_last;
   logic [15:0] res_min;
   logic [15:0] res_max;
   logic [23:0] res_sum;
   logic [7:0]  res_errors;
   logic        res_timeout;

   int total = 0;
   int bad   = 0;

   // Stub configuration: latency per trial (0 = never finishes) and corruption.
   int          lat_tab[16];
   bit          cor_tab[16];
   logic [15:0] m_seen[$];

   // Reference results.
   logic [15:0] e_last, e_min, e_max;
   logic [23:0] e_sum;
   logic [7:0]  e_err;
   logic        e_to;
   int          e_cycles;
   logic [15:0] exp_m[$];

   always #5 clk = ~clk;

   rsa_timing_probe #(
      .WIDTH    (8),
      .CNT_W    (16),
      .TRIALS_W (8),
      .TIMEOUT  (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_m           (cmd_m),
      .cmd_trials      (cmd_trials),
      .rsa_start       (rsa_start),
      .rsa_m           (rsa_m),
      .rsa_m_decrypted (rsa_m_decrypted),
      .rsa_finish      (rsa_finish),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_last        (res_last),
      .res_min         (res_min),
      .res_max         (res_max),
      .res_sum         (res_sum),
      .res_errors      (res_errors),
      .res_timeout     (res_timeout)
   );

   // RSA stub: observes each cycle just after the edge; finish rises L cycles after the start cycle.
   initial begin
      int rem;
      bit act;
      bit cor;
      int sidx;
      rem = 0; act = 0; cor = 0;
      rsa_finish = 1'b0;
      rsa_m_decrypted = '0;
      forever begin
         @(posedge clk);
         #2;
         rsa_finish = 1'b0;
         if (rst) begin
            act = 0;
         end else if (rsa_start) begin
            sidx = m_seen.size();
            m_seen.push_back(rsa_m);
            rem = (sidx < 16) ? lat_tab[sidx] : 1;
            cor = (sidx < 16) ? cor_tab[sidx] : 1'b0;
            act = (rem != 0);
         end else if (act) begin
            rem = rem - 1;
            if (rem == 0) begin
               rsa_finish = 1'b1;
               rsa_m_decrypted = cor ? (rsa_m ^ 16'h0100) : rsa_m;
               act = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Batch-level model: trial i sends base+i, latency L finishes unless L is 0 or beyond TMO+1.
   task automatic model(input logic [15:0] base, input logic [7:0] trials);
      int n;
      int l;
      n = (trials == 0) ? 1 : int'(trials);
      e_min = 16'hFFFF; e_max = 0; e_sum = 0; e_err = 0; e_to = 0; e_last = 0;
      e_cycles = 0;
      exp_m.delete();
      for (int i = 0; i < n; i++) begin
         exp_m.push_back(base + 16'(i));
         l = lat_tab[i];
         if (l == 0 || l > TMO + 1) begin
            e_to = 1;
            e_last = 16'(TMO);
            e_cycles += TMO + 3;
            break;
         end
         e_last = 16'(l);
         if (l < int'(e_min)) e_min = 16'(l);
         if (l > int'(e_max)) e_max = 16'(l);
         e_sum += 24'(l);
         if (cor_tab[i]) e_err++;
         e_cycles += l + 2;
      end
      e_cycles -= 1;
   endtask

   task automatic run_batch(input string name, input logic [15:0] base, input logic [7:0] trials,
                            input int hold, input bit noisy);
      int n;
      bit stable;
      model(base, trials);
      m_seen.delete();
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s cmd_ready got=%b exp=1", name, cmd_ready);
         return;
      end
      cmd_valid = 1'b1; cmd_m = base; cmd_trials = trials;
      tick();
      if (noisy) begin
         cmd_m = ~base; cmd_trials = 8'd3;
      end else begin
         cmd_valid = 1'b0;
      end
      n = 0;
      while (!res_valid && n < 3000) begin tick(); n++; end
      cmd_valid = 1'b0;
      total++;
      if (res_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s res_valid never rose after %0d cycles", name, n);
         return;
      end
      total++;
      if (n != e_cycles) begin bad++; $display("FAIL %s batch_cycles got=%0d exp=%0d", name, n, e_cycles); end
      total++;
      if (res_last !== e_last) begin bad++; $display("FAIL %s res_last got=%0d exp=%0d", name, res_last, e_last); end
      total++;
      if (res_min !== e_min) begin bad++; $display("FAIL %s res_min got=%0d exp=%0d", name, res_min, e_min); end
      total++;
      if (res_max !== e_max) begin bad++; $display("FAIL %s res_max got=%0d exp=%0d", name, res_max, e_max); end
      total++;
      if (res_sum !== e_sum) begin bad++; $display("FAIL %s res_sum got=%0d exp=%0d", name, res_sum, e_sum); end
      total++;
      if (res_errors !== e_err) begin bad++; $display("FAIL %s res_errors got=%0d exp=%0d", name, res_errors, e_err); end
      total++;
      if (res_timeout !== e_to) begin bad++; $display("FAIL %s res_timeout got=%b exp=%b", name, res_timeout, e_to); end
      total++;
      if (m_seen.size() != exp_m.size()) begin
         bad++;
         $display("FAIL %s start_count got=%0d exp=%0d", name, m_seen.size(), exp_m.size());
      end else begin
         for (int i = 0; i < exp_m.size(); i++) begin
            total++;
            if (m_seen[i] !== exp_m[i]) begin
               bad++;
               $display("FAIL %s rsa_m[%0d] got=%h exp=%h", name, i, m_seen[i], exp_m[i]);
            end
         end
      end
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (res_valid !== 1'b1 || res_last !== e_last || res_min !== e_min || res_max !== e_max ||
             res_sum !== e_sum || res_errors !== e_err || res_timeout !== e_to || cmd_ready !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) begin
         total++;
         if (stable !== 1'b1) begin bad++; $display("FAIL %s hold_stable got=%b exp=1", name, stable); end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s after_accept valid=%b ready=%b exp valid=0 ready=1", name, res_valid, cmd_ready);
      end
   endtask

   task automatic set_lats(input int a, input int b, input int c);
      for (int i = 0; i < 16; i++) begin lat_tab[i] = 1; cor_tab[i] = 1'b0; end
      lat_tab[0] = a; lat_tab[1] = b; lat_tab[2] = c;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      total++;
      if (rsa_start !== 1'b0 || rsa_m !== 16'h0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl start=%b m=%h valid=%b exp 0/0000/0", rsa_start, rsa_m, res_valid);
      end
      total++;
      if (res_min !== 16'hFFFF || res_max !== 16'h0 || res_sum !== 24'h0) begin
         bad++;
         $display("FAIL reset_stats min=%h max=%h sum=%h exp ffff/0/0", res_min, res_max, res_sum);
      end
      total++;
      if (res_last !== 16'h0 || res_errors !== 8'h0 || res_timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_res last=%h err=%h to=%b exp 0/0/0", res_last, res_errors, res_timeout);
      end
      rst = 1'b0;
      tick();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_single();
      set_lats(10, 1, 1);
      run_batch("single", 16'h0041, 8'd1, 0, 1'b0);
   endtask

   task automatic test_multi();
      set_lats(5, 9, 7);
      run_batch("multi", 16'h0041, 8'd3, 0, 1'b0);
   endtask

   task automatic test_corrupt();
      set_lats(5, 9, 7);
      cor_tab[1] = 1'b1;
      run_batch("corrupt", 16'h0041, 8'd3, 0, 1'b0);
   endtask

   task automatic test_timeout();
      set_lats(6, 0, 4);
      run_batch("timeout", 16'h1234, 8'd3, 2, 1'b0);
      set_lats(TMO + 1, 3, 1);
      run_batch("finish_at_timeout", 16'h0100, 8'd2, 0, 1'b0);
      set_lats(2, TMO + 2, 1);
      run_batch("just_past_timeout", 16'h0200, 8'd2, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n;
      set_lats(8, 8, 8);
      m_seen.delete();
      cmd_valid = 1'b1; cmd_m = 16'h0500; cmd_trials = 8'd3;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (m_seen.size() < 2 && n < 200) begin tick(); n++; end
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (rsa_start !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid start=%b ready=%b valid=%b exp 0/1/0", rsa_start, cmd_ready, res_valid);
      end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (res_valid !== 1'b0 || rsa_start !== 1'b0) n++;
      end
      total++;
      if (n != 0) begin bad++; $display("FAIL reset_mid_quiet active_cycles got=%0d exp=0", n); end
      set_lats(4, 6, 3);
      run_batch("after_reset", 16'h0777, 8'd3, 0, 1'b0);
   endtask

   task automatic test_zero_trials();
      set_lats(4, 4, 4);
      run_batch("zero_trials", 16'hFFFF, 8'd0, 5, 1'b0);
   endtask

   task automatic test_back_to_back();
      set_lats(1, 1, 2);
      run_batch("lat_one_noisy", 16'hFFFE, 8'd3, 0, 1'b1);
   endtask

   task automatic test_random();
      int tr;
      for (int r = 0; r < 6; r++) begin
         tr = $urandom_range(1, 6);
         for (int i = 0; i < 16; i++) begin
            lat_tab[i] = $urandom_range(1, 14);
            if ($urandom_range(0, 9) == 0) lat_tab[i] = $urandom_range(TMO, TMO + 3);
            cor_tab[i] = ($urandom_range(0, 3) == 0);
         end
         run_batch("random", 16'($urandom), 8'(tr), $urandom_range(0, 3), r[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_m = '0; cmd_trials = '0; res_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin lat_tab[i] = 1; cor_tab[i] = 1'b0; end
      test_reset();
      test_single();
      test_multi();
      test_corrupt();
      test_timeout();
      test_reset_mid();
      test_zero_trials();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsa_timing_probe.md
# rsa_timing_probe

Measurement-side counterpart of the RSA core: issues a start pulse and message to the RSA top, waits for its `finish` pulse, and records decryption latency plus correctness for a batch of trials. It sits between the test host and the RSA top, collecting the timing data the side-channel analysis consumes (per-trial latency, min/max/sum over the batch, and error count). It returns one result per batch over a valid/ready handshake.

## Interface
- `WIDTH`, 8, prime width; messages are 2*WIDTH bits
- `CNT_W`, 16, latency counter width
- `TRIALS_W`, 8, trial-count width
- `TIMEOUT`, 65535, max cycles waited for `rsa_finish` per trial
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  batch request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_m`  in  2*WIDTH  base message
- `cmd_trials`  in  TRIALS_W  trial count; 0 treated as 1
- `rsa_start`  out  1  one-cycle start pulse to RSA top (KeyGenStart)
- `rsa_m`  out  2*WIDTH  message to RSA top, held stable for the whole trial
- `rsa_m_decrypted`  in  2*WIDTH  RSA result
- `rsa_finish`  in  1  RSA done pulse
- `res_valid`  out  1  batch result available
- `res_ready`  in  1  result consumed
- `res_last`  out  CNT_W  latency of final trial
- `res_min`, `res_max`  out  CNT_W  min/max latency over batch
- `res_sum`  out  CNT_W+TRIALS_W  latency sum
- `res_errors`  out  TRIALS_W  trials where `rsa_m_decrypted != rsa_m`
- `res_timeout`  out  1  batch aborted on timeout

## Operation
- States: IDLE, LAUNCH, WAIT, GAP, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch `cmd_m`, trials (0→1), clear k, stats (min=all-ones, max=0, sum=0, errors=0, timeout=0) → LAUNCH.
- LAUNCH (1 cycle): `rsa_start`=1, `rsa_m`=base+k (mod 2^(2*WIDTH)); cnt←0 → WAIT. `rsa_finish` here is stale and ignored.
- WAIT: cnt increments (saturating at 2^CNT_W−1). On `rsa_finish`: lat=cnt+1; update min/max/sum, last=lat; errors+=1 if mismatch; k+=1; → GAP if k<trials, else DONE. If cnt reaches TIMEOUT without finish: `res_timeout`=1, last=cnt → DONE (stats so far retained).
- GAP (1 cycle): lets the RSA top return idle → LAUNCH.
- DONE: `res_valid`=1, outputs stable; on `res_ready` → IDLE.
- Message range (< n) is the caller's responsibility; wrap of base+k is plain modular addition.

## Timing
- Reset: state=IDLE, `rsa_start`=0, `rsa_m`=0, `res_valid`=0, `res_*`=0 except `res_min`=all-ones; `cmd_ready`=1 the cycle after reset deasserts.
- Reset mid-batch: aborts immediately, no result emitted, `rsa_start` low next cycle.
- Latency definition: `rsa_finish` on the cycle after `rsa_start` → lat=1.
- Trial period = lat + 2 cycles (LAUNCH + GAP); batch result valid the cycle after final finish.
- `cmd_valid` outside IDLE is ignored; `res_*` hold until handshake; `rsa_finish` while not in WAIT is ignored.
- `rsa_finish` coinciding with the timeout cycle counts as finish, not timeout.

## Structure
- Package `rsa_probe_pkg`: state encoding constants, default `CNT_W`/`TRIALS_W`/`TIMEOUT`.
- Sub-module `rsa_lat_stats`: clear/update-driven min/max/sum/error accumulator; FSM and counter stay in the top.

## Test plan
- Behavioural RSA stub, fixed latency 10, echoes m; cmd_m=0x0041, trials=1 → res_last=10, min=max=sum=10, errors=0.
- Stub latency cycling 5,9,7 over trials=3 → min=5, max=9, sum=21, rsa_m seen as 0x0041,0x0042,0x0043.
- Stub corrupts trial 2 output → errors=1, other stats unchanged.
- Stub never finishes, TIMEOUT=20 → res_timeout=1, res_last=20, res_valid asserted.
- Assert rst during WAIT of trial 2 → IDLE next cycle, no res_valid; new batch runs cleanly.
- cmd_trials=0, cmd_m=0xFFFF → exactly one trial; res_ready held low 5 cycles → outputs stable until accepted.
